sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer. It is the receive end of the word link that carries parallel data over a single serial bit lane. It collects framed serial bits, MSB first, into WIDTH-bit words and presents each completed word on a held parallel output with a valid/ready handshake. It sits in front of the parallel register stages (d_in/d_out style) in the datapath and flags words lost to backpressure.

---
 rtl/sipo_deser.sv | 128 ++++++++++++
 tb/tb_sipo_deser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer.
// Collects framed serial bits (MSB first) into WIDTH-bit words and presents
// each completed word on a held parallel output with a valid/ready handshake.
// A word that completes while the previous one is still stalled is dropped
// and recorded in the sticky overrun flag.
module sipo_deser #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic             s_start,
   input  logic             s_in,
   output logic [WIDTH-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             overrun,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]   d_out_q, d_out_d;
   logic               d_valid_q, d_valid_d;
   logic               overrun_q, overrun_d;

   logic [WIDTH-1:0]   shifted_s;
   logic               complete_s;
   logic               consume_s;

   // Shift register contents after taking in the current serial bit.
   assign shifted_s = {sh_q[WIDTH-2:0], s_in};
   assign consume_s = d_valid_q & d_ready;

   // Next-state logic: framing FSM, bit counter, shifter and output handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      d_out_d    = d_out_q;
      d_valid_d  = d_valid_q;
      overrun_d  = overrun_q;
      complete_s = 1'b0;

      if (s_valid) begin
         // Every accepted bit enters the shifter; only the last WIDTH matter.
         sh_d = shifted_s;
         case (state_q)
            IDLE: begin
               if (s_start) begin
                  cnt_d   = CNT_W'(1);
                  state_d = RECV;
               end else begin
                  // Stray bit outside a frame: nothing to record.
                  state_d = IDLE;
               end
            end
            RECV: begin
               if (s_start) begin
                  // Resynchronise: abandon the partial word, this bit is the MSB.
                  cnt_d   = CNT_W'(1);
                  state_d = RECV;
               end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  complete_s = 1'b1;
                  cnt_d      = '0;
                  state_d    = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      if (complete_s) begin
         if (!d_valid_q || consume_s) begin
            // Output slot is free (or being freed this edge): no bubble.
            d_out_d   = shifted_s;
            d_valid_d = 1'b1;
         end else begin
            // Downstream still holds the previous word: drop the new one.
            overrun_d = 1'b1;
         end
      end else if (consume_s) begin
         d_valid_d = 1'b0;
      end else begin
         d_valid_d = d_valid_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sh_q      <= '0;
         d_out_q   <= '0;
         d_valid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
         d_out_q   <= d_out_d;
         d_valid_q <= d_valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign d_out   = d_out_q;
   assign d_valid = d_valid_q;
   assign overrun = overrun_q;
   assign busy    = (state_q == RECV);

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed plus randomized bench for sipo_deser.
// A bit-list reference model pushes each word the design should present into
// a queue; an independent negedge monitor pops and compares on consumption.
module tb_sipo_deser;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_start = 1'b0;
   logic         s_in = 1'b0;
   logic         d_ready = 1'b0;
   logic [W-1:0] d_out;
   logic         d_valid;
   logic         overrun;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Reference model state: bits of the current frame, expected words,
   // and whether an unconsumed word / overrun should be visible.
   bit           mbits[$];
   logic [W-1:0] exp_q[$];
   bit           m_valid = 1'b0;
   bit           m_overrun = 1'b0;
   bit           started = 1'b0;

   sipo_deser #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .s_valid(s_valid),
      .s_start(s_start),
      .s_in   (s_in),
      .d_out  (d_out),
      .d_valid(d_valid),
      .d_ready(d_ready),
      .overrun(overrun),
      .busy   (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Apply one cycle of inputs, let the edge happen, then advance the model.
   task automatic step(input bit r, input bit v, input bit st, input bit b, input bit rdy);
      bit           consume;
      bit           done;
      logic [W-1:0] w;
      rst = r; s_valid = v; s_start = st; s_in = b; d_ready = rdy;
      @(posedge clk);
      if (r) begin
         mbits.delete();
         exp_q.delete();
         m_valid   = 1'b0;
         m_overrun = 1'b0;
      end else begin
         consume = m_valid && rdy;
         done    = 1'b0;
         w       = '0;
         if (v) begin
            if (st) begin
               mbits.delete();
               mbits.push_back(b);
            end else if (mbits.size() != 0) begin
               mbits.push_back(b);
            end
            if (mbits.size() == W) begin
               for (int i = 0; i < W; i++) w = W'(w * 2 + mbits[i]);
               mbits.delete();
               done = 1'b1;
            end
         end
         if (done) begin
            if (!m_valid || consume) begin
               exp_q.push_back(w);
               m_valid = 1'b1;
            end else begin
               m_overrun = 1'b1;
            end
         end else if (consume) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   // Send one framed word MSB first, with 'gap' idle cycles after each bit.
   task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy);
      for (int i = 0; i < W; i++) begin
         step(1'b0, 1'b1, (i == 0), w[W-1-i], rdy);
         if (i < W - 1) idle(gap, rdy);
      end
   endtask

   // Monitor: compare status each cycle and pop the expected word on consume.
   always @(negedge clk) begin
      if (started) begin
         chk("d_valid", d_valid, m_valid);
         chk("overrun", overrun, m_overrun);
         chk("busy", busy, mbits.size() != 0);
         if (d_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 1, 0);
            end else if (d_ready) begin
               chk("d_out_consumed", d_out, exp_q.pop_front());
            end else begin
               chk("d_out_held", d_out, exp_q[0]);
            end
         end
      end
   end

   initial begin
      // 1. Reset with random serial activity.
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      started = 1'b1;
      chk("rst_d_out", d_out, 4'b0000);
      chk("rst_d_valid", d_valid, 1'b0);
      chk("rst_overrun", overrun, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // 2. Basic word, back-to-back bits.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      chk("t2_busy1", busy, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t2_busy3", busy, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t2_d_out", d_out, 4'b1011);
      chk("t2_d_valid", d_valid, 1'b1);
      chk("t2_busy_done", busy, 1'b0);
      idle(1, 1'b1);
      chk("t2_d_valid_one", d_valid, 1'b0);

      // 3. Stray bit, then gapped word.
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t3_stray_busy", busy, 1'b0);
      send_word(4'b0110, 2, 1'b0);
      chk("t3_d_out", d_out, 4'b0110);
      idle(2, 1'b1);

      // 4. Resync after two bits.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      send_word(4'b0010, 0, 1'b0);
      chk("t4_d_out", d_out, 4'b0010);
      idle(2, 1'b1);

      // 5a. Backpressure overrun.
      send_word(4'b1111, 0, 1'b0);
      send_word(4'b0001, 0, 1'b0);
      chk("t5_d_out", d_out, 4'b1111);
      chk("t5_overrun", overrun, 1'b1);
      // 5b. Consume and complete on the same edge.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(4'b1111, 0, 1'b0);
      for (int i = 0; i < W; i++)
         step(1'b0, 1'b1, (i == 0), (i == 0), (i == W - 1));
      d_ready = 1'b0;
      #1;
      chk("t5b_d_out", d_out, 4'b1000);
      chk("t5b_d_valid", d_valid, 1'b1);
      chk("t5b_overrun", overrun, 1'b0);
      idle(2, 1'b1);

      // 6. Reset mid-word.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_busy_rst", busy, 1'b0);
      send_word(4'b1101, 0, 1'b0);
      chk("t6_d_out", d_out, 4'b1101);
      chk("t6_overrun", overrun, 1'b0);
      idle(2, 1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0),
              1'($urandom),
              1'($urandom));
      end
      idle(4, 1'b1);
      chk("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
